// File: rtl/twiddle_sequencer_pkg.sv
// Shared constants for the 16-point SDF FFT twiddle path: default widths,
// the W16^e table for e = 0..9 and the sequencer state type.
package fft_pkg;

  localparam int WIDTH_DEF       = 16;
  localparam int FIXED_POINT_DEF = 11;

  // round(2^11 * cos(2*pi*e/16)) and round(-2^11 * sin(2*pi*e/16)), e = 0..9
  localparam logic signed [15:0] TW_RE [10] = '{
    16'sd2048, 16'sd1892, 16'sd1448, 16'sd784, 16'sd0,
    -16'sd784, -16'sd1448, -16'sd1892, -16'sd2048, -16'sd1892
  };
  localparam logic signed [15:0] TW_IM [10] = '{
    16'sd0, -16'sd784, -16'sd1448, -16'sd1892, -16'sd2048,
    -16'sd1892, -16'sd1448, -16'sd784, 16'sd0, 16'sd784
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [1:0] brev2(input logic [1:0] q);
    return {q[0], q[1]};
  endfunction

endpackage

// File: rtl/twiddle_sequencer_if.sv
// Sample-in / multiplier-feed bundle between the first butterfly pair and
// the complex multiplier.
interface twiddle_sequencer_if
  import fft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic                    In_Valid;
  logic                    Frame_Start;
  logic signed [WIDTH-1:0] In_Re;
  logic signed [WIDTH-1:0] In_Im;
  logic                    Out_Valid;
  logic signed [WIDTH-1:0] Data_Re;
  logic signed [WIDTH-1:0] Data_Im;
  logic signed [WIDTH-1:0] Tw_Re;
  logic signed [WIDTH-1:0] Tw_Im;
  logic                    Mul_Enable;
  logic                    Frame_Done;
  logic                    Resync;

  modport master (
    output In_Valid, Frame_Start, In_Re, In_Im,
    input  Out_Valid, Data_Re, Data_Im, Tw_Re, Tw_Im, Mul_Enable, Frame_Done, Resync
  );

  modport slave (
    input  In_Valid, Frame_Start, In_Re, In_Im,
    output Out_Valid, Data_Re, Data_Im, Tw_Re, Tw_Im, Mul_Enable, Frame_Done, Resync
  );
endinterface

// File: rtl/twiddle_rom.sv
// Combinational W16^e lookup; exponents outside 0..9 never occur in a
// radix-2^2 16-point frame and fall back to W16^0.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]              e,
  output logic signed [WIDTH-1:0] tw_re,
  output logic signed [WIDTH-1:0] tw_im
);

  always_comb begin
    tw_re = WIDTH'(TW_RE[0]);
    tw_im = WIDTH'(TW_IM[0]);
    if (e < 4'd10) begin
      tw_re = WIDTH'(TW_RE[e]);
      tw_im = WIDTH'(TW_IM[e]);
    end
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// Frame index counter, twiddle exponent derivation and aligned output
// registers feeding the complex multiplier of the 16-point SDF FFT.
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int FIXED_POINT = FIXED_POINT_DEF
) (
  input logic                clk,
  input logic                rst,
  twiddle_sequencer_if.slave io
);

  if (FIXED_POINT != 11) begin : g_fixed_point_check
    $error("twiddle_sequencer: twiddle ROM is defined only for FIXED_POINT = 11");
  end

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic                    vld_p0, fs_p0;
  logic [3:0]              cur_idx_p0, exp_p0;
  logic signed [WIDTH-1:0] rom_re_p0, rom_im_p0;
  logic                    vld_p1, frame_done_p1, resync_p1;
  logic signed [WIDTH-1:0] data_re_p1, data_im_p1, tw_re_p1, tw_im_p1;

  assign vld_p0 = io.In_Valid;
  assign fs_p0  = io.In_Valid & io.Frame_Start;

  // A qualified Frame_Start forces the current sample to index 0.
  always_comb begin
    cur_idx_p0 = idx_q;
    if (fs_p0 || state_q == IDLE) cur_idx_p0 = 4'd0;
    exp_p0 = {2'b00, brev2(cur_idx_p0[3:2])} * {2'b00, cur_idx_p0[1:0]};
  end

  twiddle_rom #(.WIDTH(WIDTH)) u_rom (
    .e     (exp_p0),
    .tw_re (rom_re_p0),
    .tw_im (rom_im_p0)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (vld_p0) begin
          state_d = RUN;
          idx_d   = 4'd1;
        end
      end
      RUN: begin
        if (vld_p0) idx_d = cur_idx_p0 + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // p0 -> p1: data and twiddle load only on valid samples and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1        <= 1'b0;
      frame_done_p1 <= 1'b0;
      resync_p1     <= 1'b0;
      data_re_p1    <= '0;
      data_im_p1    <= '0;
      tw_re_p1      <= WIDTH'(TW_RE[0]);
      tw_im_p1      <= WIDTH'(TW_IM[0]);
    end else begin
      vld_p1        <= vld_p0;
      frame_done_p1 <= vld_p0 && (cur_idx_p0 == 4'd15);
      resync_p1     <= fs_p0 && (idx_q != 4'd0);
      if (vld_p0) begin
        data_re_p1 <= io.In_Re;
        data_im_p1 <= io.In_Im;
        tw_re_p1   <= rom_re_p0;
        tw_im_p1   <= rom_im_p0;
      end
    end
  end

  assign io.Out_Valid  = vld_p1;
  assign io.Mul_Enable = vld_p1;
  assign io.Frame_Done = frame_done_p1;
  assign io.Resync     = resync_p1;
  assign io.Data_Re    = data_re_p1;
  assign io.Data_Im    = data_im_p1;
  assign io.Tw_Re      = tw_re_p1;
  assign io.Tw_Im      = tw_im_p1;

endmodule
